fetch_sequencer: RTL and testbench

Controller that sequences serial-memory fetches around the program counter. It gates the serial clock, drives `pcEn`, and assembles serial bits into bytes. It hands bytes to a downstream consumer through a valid/ready handshake and stalls the fetch when the consumer back-pressures. It sits between the serial clock generator / program counter pair and the byte-consuming logic.

---
 rtl/fetch_sequencer_pkg.sv | 16 +
 rtl/fetch_sequencer_byte_assembler.sv | 70 +++++++
 rtl/fetch_sequencer.sv | 250 +++++++++++++++++++++++++
 tb/tb_fetch_sequencer.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_sequencer_pkg.sv
// fetch_sequencer_pkg
//   Shared definitions for the serial fetch sequencer: the controller state
//   encoding and the default address width / header boundary.
package fetch_sequencer_pkg;

  localparam int DEF_ADDR_WIDTH = 16;
  // First non-header address; the program counter wraps to this value.
  localparam int DEF_HEADER_END = 93;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2
  } fseq_state_e;

endpackage

// File: rtl/fetch_sequencer_byte_assembler.sv
// byte_assembler
//   Serial-to-parallel byte assembly for the fetch sequencer, plus a one-byte
//   hold register used while the downstream consumer back-pressures.
//   Ports:
//     clk, resetN     - clock, async active-low reset
//     clr_i           - flush the partial byte (new fetch / abort)
//     shiftEn_i       - shift sdi_i in (serial clock rising edge while fetching)
//     completeEn_i    - this serial edge completes a byte
//     holdLoad_i      - capture the completed byte and its address
//     sdi_i, addr_i   - serial data bit, address of the byte being completed
//     byte_o          - completed byte {previous 7 bits, sdi_i}
//     complete_o      - byte-complete strobe
//     holdData_o/holdAddr_o - held byte and its address
module byte_assembler
  import fetch_sequencer_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  resetN,
  input  logic                  clr_i,
  input  logic                  shiftEn_i,
  input  logic                  completeEn_i,
  input  logic                  holdLoad_i,
  input  logic                  sdi_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  output logic [7:0]            byte_o,
  output logic                  complete_o,
  output logic [7:0]            holdData_o,
  output logic [ADDR_WIDTH-1:0] holdAddr_o
);

  // Only the last seven bits are ever needed: the eighth is sdi itself on
  // the completing edge.
  logic [6:0]            shift_q, shift_d;
  logic [7:0]            holdData_q, holdData_d;
  logic [ADDR_WIDTH-1:0] holdAddr_q, holdAddr_d;

  assign byte_o     = {shift_q, sdi_i};
  assign complete_o = completeEn_i;
  assign holdData_o = holdData_q;
  assign holdAddr_o = holdAddr_q;

  always_comb begin
    shift_d    = shift_q;
    holdData_d = holdData_q;
    holdAddr_d = holdAddr_q;
    if (clr_i)
      shift_d = '0;
    else if (shiftEn_i)
      shift_d = byte_o[6:0];
    if (holdLoad_i) begin
      holdData_d = byte_o;
      holdAddr_d = addr_i;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      shift_q    <= '0;
      holdData_q <= '0;
      holdAddr_q <= '0;
    end else begin
      shift_q    <= shift_d;
      holdData_q <= holdData_d;
      holdAddr_q <= holdAddr_d;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer
//   Sequences serial-memory fetches around the program counter: enables the
//   serial clock and PC, assembles bytes, and hands them to a consumer over a
//   valid/ready handshake, pausing the serial clock under back-pressure.
//   Optional feature macro: FETCH_SEQ_HEADER_EN (adds outHeader/headerDone
//   and the HEADER_END parameter).
//   Ports:
//     clk, resetN                - clock, async active-low reset
//     sclkPosEdge, sclk8PosEdge  - serial clock edge / every 8th edge strobes
//     sdi, memAddr               - serial data (MSB first), program counter
//     start, fetchLen, abort     - fetch control
//     outReady                   - consumer ready
//     pcEn, sclkEn, csN          - registered PC enable, sclk enable, chip sel
//     outData, outAddr, outValid - output byte, its address, valid
//     busy, done                 - not idle, final-byte pulse
//     outHeader, headerDone      - header classification (feature only)
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
`ifdef FETCH_SEQ_HEADER_EN
  ,
  parameter int HEADER_END = DEF_HEADER_END
`endif
) (
  input  logic                  clk,
  input  logic                  resetN,
  input  logic                  sclkPosEdge,
  input  logic                  sclk8PosEdge,
  input  logic                  sdi,
  input  logic [ADDR_WIDTH-1:0] memAddr,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] fetchLen,
  input  logic                  abort,
  input  logic                  outReady,
  output logic                  pcEn,
  output logic                  sclkEn,
  output logic                  csN,
  output logic [7:0]            outData,
  output logic [ADDR_WIDTH-1:0] outAddr,
  output logic                  outValid,
  output logic                  busy,
`ifdef FETCH_SEQ_HEADER_EN
  output logic                  outHeader,
  output logic                  headerDone,
`endif
  output logic                  done
);

  fseq_state_e           state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  pcEn_q, pcEn_d;
  logic                  sclkEn_q, sclkEn_d;
  logic                  csN_q, csN_d;
  logic                  outValid_q, outValid_d;
  logic                  done_q, done_d;
  logic [7:0]            outData_q, outData_d;
  logic [ADDR_WIDTH-1:0] outAddr_q, outAddr_d;

  logic                  inIdle, inFetch, inHold;
  logic                  startSeen, acceptStart, zeroStart;
  logic                  byteDone, slotFree, loadNew, toHold;
  logic                  holdRelease, lastFetch, holdEmpty, finish;
  logic                  asmClr, holdLoad, completeEn;
  logic [7:0]            asmByte, holdData;
  logic [ADDR_WIDTH-1:0] holdAddr;

  byte_assembler #(.ADDR_WIDTH(ADDR_WIDTH)) u_asm (
    .clk         (clk),
    .resetN      (resetN),
    .clr_i       (asmClr),
    .shiftEn_i   (inFetch && sclkPosEdge),
    .completeEn_i(completeEn),
    .holdLoad_i  (holdLoad),
    .sdi_i       (sdi),
    .addr_i      (memAddr),
    .byte_o      (asmByte),
    .complete_o  (byteDone),
    .holdData_o  (holdData),
    .holdAddr_o  (holdAddr)
  );

  // Shared decode; abort masks every other event in the same cycle.
  assign inIdle      = (state_q == ST_IDLE);
  assign inFetch     = (state_q == ST_FETCH);
  assign inHold      = (state_q == ST_HOLD);
  assign startSeen   = inIdle && start && !abort;
  assign acceptStart = startSeen && (fetchLen != '0);
  assign zeroStart   = startSeen && (fetchLen == '0);
  assign completeEn  = inFetch && sclk8PosEdge && !abort;
  // Slot counts as free when its current byte is being taken this cycle.
  assign slotFree    = !outValid_q || outReady;
  assign loadNew     = byteDone && slotFree;
  assign toHold      = byteDone && !slotFree;
  assign holdRelease = inHold && outValid_q && outReady && !abort;
  assign lastFetch   = (cnt_q == ADDR_WIDTH'(1));
  // In HOLD the count was already decremented for the held byte.
  assign holdEmpty   = (cnt_q == '0);
  assign finish      = (loadNew && lastFetch) || (holdRelease && holdEmpty);

  // State register
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  if (acceptStart) state_d = ST_FETCH;
        ST_FETCH: begin
          if (finish)      state_d = ST_IDLE;
          else if (toHold) state_d = ST_HOLD;
        end
        ST_HOLD:  if (holdRelease) state_d = holdEmpty ? ST_IDLE : ST_FETCH;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // Output / datapath next-state logic
  always_comb begin
    pcEn_d     = pcEn_q;
    sclkEn_d   = sclkEn_q;
    csN_d      = csN_q;
    outValid_d = outValid_q && !outReady;
    outData_d  = outData_q;
    outAddr_d  = outAddr_q;
    done_d     = 1'b0;
    cnt_d      = cnt_q;
    holdLoad   = 1'b0;
    asmClr     = 1'b0;
    if (abort) begin
      pcEn_d     = 1'b0;
      sclkEn_d   = 1'b0;
      csN_d      = 1'b1;
      outValid_d = 1'b0;
      cnt_d      = '0;
      asmClr     = 1'b1;
    end else begin
      if (acceptStart) begin
        cnt_d    = fetchLen;
        csN_d    = 1'b0;
        sclkEn_d = 1'b1;
        pcEn_d   = 1'b1;
        asmClr   = 1'b1;
      end
      if (zeroStart) done_d = 1'b1;
      if (byteDone) cnt_d = cnt_q - ADDR_WIDTH'(1);
      // memAddr is still the pre-increment PC on the completing edge.
      if (loadNew) begin
        outData_d  = asmByte;
        outAddr_d  = memAddr;
        outValid_d = 1'b1;
      end
      // Pausing sclk freezes the bit phase, so resuming loses nothing.
      if (toHold) begin
        holdLoad = 1'b1;
        pcEn_d   = 1'b0;
        sclkEn_d = 1'b0;
      end
      if (holdRelease) begin
        outData_d  = holdData;
        outAddr_d  = holdAddr;
        outValid_d = 1'b1;
        if (!holdEmpty) begin
          pcEn_d   = 1'b1;
          sclkEn_d = 1'b1;
        end
      end
      if (finish) begin
        pcEn_d   = 1'b0;
        sclkEn_d = 1'b0;
        csN_d    = 1'b1;
        done_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      pcEn_q     <= 1'b0;
      sclkEn_q   <= 1'b0;
      csN_q      <= 1'b1;
      outValid_q <= 1'b0;
      outData_q  <= '0;
      outAddr_q  <= '0;
      done_q     <= 1'b0;
      cnt_q      <= '0;
    end else begin
      pcEn_q     <= pcEn_d;
      sclkEn_q   <= sclkEn_d;
      csN_q      <= csN_d;
      outValid_q <= outValid_d;
      outData_q  <= outData_d;
      outAddr_q  <= outAddr_d;
      done_q     <= done_d;
      cnt_q      <= cnt_d;
    end
  end

  assign pcEn     = pcEn_q;
  assign sclkEn   = sclkEn_q;
  assign csN      = csN_q;
  assign outValid = outValid_q;
  assign outData  = outData_q;
  assign outAddr  = outAddr_q;
  assign done     = done_q;
  assign busy     = !inIdle;

`ifdef FETCH_SEQ_HEADER_EN
  localparam logic [ADDR_WIDTH-1:0] HDR_END = ADDR_WIDTH'(HEADER_END);

  logic                  outHeader_q, outHeader_d;
  logic                  headerDone_q, headerDone_d;
  logic                  outLoad;
  logic [ADDR_WIDTH-1:0] loadAddr;

  assign outLoad  = loadNew || holdRelease;
  assign loadAddr = holdRelease ? holdAddr : memAddr;

  always_comb begin
    outHeader_d  = outHeader_q;
    headerDone_d = headerDone_q;
    if (outLoad) outHeader_d = (loadAddr < HDR_END);
    if (startSeen)
      headerDone_d = 1'b0;
    else if (outLoad && (loadAddr >= HDR_END))
      headerDone_d = 1'b1;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      outHeader_q  <= 1'b0;
      headerDone_q <= 1'b0;
    end else begin
      outHeader_q  <= outHeader_d;
      headerDone_q <= headerDone_d;
    end
  end

  assign outHeader  = outHeader_q;
  assign headerDone = headerDone_q;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer
//   Environment models the serial clock generator, serial memory and program
//   counter; a scoreboard queue holds the bytes each fetch should deliver and
//   a monitor checks every byte the sequencer presents.
module tb_fetch_sequencer;

  localparam int AW  = 16;
  localparam int DIV = 3;          // clk cycles per serial clock period
  localparam int HDR = 93;

  logic          clk = 1'b0;
  logic          resetN = 1'b0;
  logic          sclkPosEdge = 1'b0, sclk8PosEdge = 1'b0, sdi = 1'b0;
  logic [AW-1:0] memAddr = '0, fetchLen = '0;
  logic          start = 1'b0, abort = 1'b0, outReady = 1'b0;
  logic          pcEn, sclkEn, csN, outValid, busy, done;
  logic [7:0]    outData;
  logic [AW-1:0] outAddr;
`ifdef FETCH_SEQ_HEADER_EN
  logic          outHeader, headerDone;
`endif

  always #5 clk = ~clk;

  fetch_sequencer dut (
    .clk         (clk),
    .resetN      (resetN),
    .sclkPosEdge (sclkPosEdge),
    .sclk8PosEdge(sclk8PosEdge),
    .sdi         (sdi),
    .memAddr     (memAddr),
    .start       (start),
    .fetchLen    (fetchLen),
    .abort       (abort),
    .outReady    (outReady),
    .pcEn        (pcEn),
    .sclkEn      (sclkEn),
    .csN         (csN),
    .outData     (outData),
    .outAddr     (outAddr),
    .outValid    (outValid),
    .busy        (busy),
`ifdef FETCH_SEQ_HEADER_EN
    .outHeader   (outHeader),
    .headerDone  (headerDone),
`endif
    .done        (done)
  );

  typedef struct {
    logic [7:0]    data;
    logic [AW-1:0] addr;
    bit            last;
  } exp_t;

  exp_t          expQ[$];
  int            nChk = 0, nPass = 0;
  logic [7:0]    stream[16];
  int            readyMode = 1;   // 0: never ready, 1: always, 2: random
  int            pcPulses = 0;
  int            byteIdx = 0, bitIdx = 0;
  int            seedCnt = 0, startCnt = 0, zeroIssued = 0, zeroSeen = 0;
  logic [AW-1:0] seedVal = '0;

  function automatic logic [AW-1:0] pcNext(input logic [AW-1:0] a);
    return (a == '1) ? AW'(HDR) : a + AW'(1);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChk++;
    if (act === exp) nPass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Serial clock generator, serial memory and program counter.
  initial begin
    int         div;
    int         seedSeen;
    bit         pcAdv;
    logic [7:0] cur;
    div = 0; seedSeen = 0; pcAdv = 0;
    forever begin
      @(negedge clk);
      if (pcAdv) memAddr = pcNext(memAddr);
      if (seedCnt != seedSeen) begin
        memAddr  = seedVal;
        seedSeen = seedCnt;
      end
      sclkPosEdge  = 1'b0;
      sclk8PosEdge = 1'b0;
      if (csN || !resetN) begin
        div = 0; bitIdx = 0; byteIdx = 0;
      end else if (sclkEn) begin
        if (div == DIV - 1) begin
          div = 0;
          cur = stream[byteIdx % 16];
          sdi = cur[7 - bitIdx];
          sclkPosEdge = 1'b1;
          if (bitIdx == 7) begin
            sclk8PosEdge = 1'b1;
            bitIdx = 0;
            byteIdx++;
          end else begin
            bitIdx++;
          end
        end else begin
          div++;
        end
      end
      pcAdv = pcEn && sclk8PosEdge;
      if (pcAdv) pcPulses++;
      case (readyMode)
        0:       outReady = 1'b0;
        1:       outReady = 1'b1;
        default: outReady = ($urandom_range(0, 99) < 60);
      endcase
    end
  end

  // Monitor: every newly presented byte is checked against the scoreboard.
  initial begin
    bit   pv, pr, nb;
    exp_t e;
    int   startSeenM;
    bit   hdrSticky;
    pv = 0; pr = 0; startSeenM = 0; hdrSticky = 0;
    forever begin
      @(negedge clk);
      #1;
      if (!resetN) begin
        pv = 0; pr = 0; hdrSticky = 0;
        continue;
      end
      if (startSeenM != startCnt) begin
        startSeenM = startCnt;
        hdrSticky  = 0;
      end
      nb = outValid && (!pv || pr);
      if (nb) begin
        if (expQ.size() == 0) begin
          chk("unexpected byte", {24'd0, outData}, 32'hFFFF_FFFF);
        end else begin
          e = expQ.pop_front();
          chk("byte data", {24'd0, outData}, {24'd0, e.data});
          chk("byte addr", {16'd0, outAddr}, {16'd0, e.addr});
          chk("done with byte", {31'd0, done}, {31'd0, e.last});
`ifdef FETCH_SEQ_HEADER_EN
          if (e.addr >= AW'(HDR)) hdrSticky = 1;
          chk("outHeader", {31'd0, outHeader}, {31'd0, (e.addr < AW'(HDR))});
          chk("headerDone", {31'd0, headerDone}, {31'd0, hdrSticky});
`endif
        end
      end else if (done) begin
        if (zeroSeen < zeroIssued) begin
          zeroSeen++;
          chk("zero-length done", 1, 1'b1 && done);
        end else begin
          chk("spurious done", {31'd0, done}, 0);
        end
      end
      pv = outValid;
      pr = outReady;
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic setPc(input logic [AW-1:0] a);
    seedVal = a;
    seedCnt++;
    @(negedge clk); #3;
  endtask

  task automatic pulseStart(input logic [AW-1:0] len, input bit accepted);
    fetchLen = len;
    start    = 1'b1;
    if (accepted) startCnt++;
    @(negedge clk); #3;
    start = 1'b0;
  endtask

  task automatic waitIdle(input string tag, input int budget);
    int n = 0;
    while (busy && n < budget) begin
      @(negedge clk); #3;
      n++;
    end
    chk({tag, " idle in budget"}, {31'd0, busy}, 0);
  endtask

  task automatic checkResetVals(input string tag);
    chk({tag, " pcEn"}, {31'd0, pcEn}, 0);
    chk({tag, " sclkEn"}, {31'd0, sclkEn}, 0);
    chk({tag, " csN"}, {31'd0, csN}, 1);
    chk({tag, " outValid"}, {31'd0, outValid}, 0);
    chk({tag, " outData"}, {24'd0, outData}, 0);
    chk({tag, " outAddr"}, {16'd0, outAddr}, 0);
    chk({tag, " busy"}, {31'd0, busy}, 0);
    chk({tag, " done"}, {31'd0, done}, 0);
  endtask

  task automatic pushExp(input int len, input logic [AW-1:0] pc, output logic [AW-1:0] endPc);
    logic [AW-1:0] a = pc;
    for (int i = 0; i < len; i++) begin
      expQ.push_back('{data: stream[i], addr: a, last: (i == len - 1)});
      a = pcNext(a);
    end
    endPc = a;
  endtask

  task automatic runFetch(input string tag, input int len, input logic [AW-1:0] pc,
                          input int mode, input bit midStart);
    logic [AW-1:0] endPc;
    int            p0;
    readyMode = mode;
    setPc(pc);
    pushExp(len, pc, endPc);
    p0 = pcPulses;
    pulseStart(AW'(len), 1'b1);
    if (midStart) begin
      repeat (10) begin @(negedge clk); #3; end
      pulseStart(AW'(9), 1'b0);
    end
    waitIdle(tag, 4000);
    readyMode = 1;
    repeat (4) begin @(negedge clk); #3; end
    chk({tag, " scoreboard drained"}, expQ.size(), 0);
    chk({tag, " pc pulses"}, pcPulses - p0, len);
    chk({tag, " final pc"}, {16'd0, memAddr}, {16'd0, endPc});
    chk({tag, " csN idle"}, {31'd0, csN}, 1);
  endtask

  initial begin
    logic [AW-1:0] endPc;
    logic [AW-1:0] frozen;
    int            p0, n;
    bit            ok;

    for (int i = 0; i < 16; i++) stream[i] = 8'($urandom);
    repeat (2) @(negedge clk);
    #3;
    checkResetVals("reset");
    resetN = 1'b1;
    repeat (2) begin @(negedge clk); #3; end

    // Basic fetch
    stream[0] = 8'hA5; stream[1] = 8'h3C; stream[2] = 8'hFF;
    runFetch("basic", 3, AW'(100), 1, 1'b0);

    // Back-pressure: second byte waits in HOLD
    stream[0] = 8'h5A; stream[1] = 8'hC3;
    readyMode = 0;
    setPc(AW'(300));
    pushExp(2, AW'(300), endPc);
    p0 = pcPulses;
    pulseStart(AW'(2), 1'b1);
    n = 0;
    while ((pcPulses - p0) < 2 && n < 1000) begin @(negedge clk); #3; n++; end
    chk("bp both bytes completed", pcPulses - p0, 2);
    @(negedge clk); #3;
    frozen = memAddr;
    chk("bp pc after two bytes", {16'd0, frozen}, {16'd0, endPc});
    ok = 1;
    repeat (20) begin
      @(negedge clk); #3;
      if (sclkEn || pcEn || memAddr != frozen || !busy || !outValid || outData != 8'h5A) ok = 0;
    end
    chk("bp hold frozen", {31'd0, ok}, 1);
    readyMode = 1;
    @(negedge clk); #3;
    @(negedge clk); #3;
    chk("bp second valid", {31'd0, outValid}, 1);
    chk("bp second data", {24'd0, outData}, 32'hC3);
    chk("bp second addr", {16'd0, outAddr}, 301);
    chk("bp done", {31'd0, done}, 1);
    chk("bp idle", {31'd0, busy}, 0);
    repeat (3) begin @(negedge clk); #3; end
    chk("bp drained", expQ.size(), 0);

    // Abort during bit 4 of byte 2
    for (int i = 0; i < 16; i++) stream[i] = 8'($urandom);
    readyMode = 1;
    setPc(AW'(200));
    pushExp(4, AW'(200), endPc);
    pulseStart(AW'(4), 1'b1);
    n = 0;
    while (!(byteIdx == 1 && bitIdx == 4) && n < 1000) begin @(negedge clk); #3; n++; end
    chk("abort point reached", {31'd0, (byteIdx == 1 && bitIdx == 4)}, 1);
    abort = 1'b1;
    @(negedge clk); #3;
    abort = 1'b0;
    chk("abort outValid", {31'd0, outValid}, 0);
    chk("abort busy", {31'd0, busy}, 0);
    chk("abort csN", {31'd0, csN}, 1);
    chk("abort pcEn", {31'd0, pcEn}, 0);
    chk("abort sclkEn", {31'd0, sclkEn}, 0);
    chk("abort bytes left", expQ.size(), 3);
    expQ.delete();
    repeat (30) begin @(negedge clk); #3; end
    runFetch("after abort", 2, AW'(210), 1, 1'b0);

    // Zero length
    zeroIssued++;
    pulseStart(AW'(0), 1'b1);
    chk("zero done", {31'd0, done}, 1);
    chk("zero csN", {31'd0, csN}, 1);
    chk("zero busy", {31'd0, busy}, 0);
    @(negedge clk); #3;
    chk("zero done single", {31'd0, done}, 0);
    chk("zero done seen", zeroSeen, zeroIssued);

    // Start while busy is ignored
    for (int i = 0; i < 16; i++) stream[i] = 8'($urandom);
    runFetch("ignored start", 4, AW'(500), 1, 1'b1);

    // Header boundary and PC wrap
    for (int i = 0; i < 16; i++) stream[i] = 8'($urandom);
    runFetch("header", 5, AW'(91), 1, 1'b0);
    runFetch("wrap", 3, 16'hFFFE, 2, 1'b0);

    // Reset mid-fetch
    readyMode = 1;
    setPc(AW'(700));
    pushExp(4, AW'(700), endPc);
    pulseStart(AW'(4), 1'b1);
    n = 0;
    while (byteIdx < 2 && n < 1000) begin @(negedge clk); #3; n++; end
    resetN = 1'b0;
    #1;
    checkResetVals("mid reset");
    expQ.delete();
    @(negedge clk); #3;
    resetN = 1'b1;
    repeat (2) begin @(negedge clk); #3; end

    // Randomized fetches with random back-pressure
    for (int t = 0; t < 10; t++) begin
      logic [AW-1:0] pc;
      for (int i = 0; i < 16; i++) stream[i] = 8'($urandom);
      pc = ($urandom_range(0, 3) == 0) ? AW'(16'hFFFF - $urandom_range(0, 3))
                                       : AW'($urandom_range(0, 400));
      runFetch("random", $urandom_range(1, 6), pc, 2, 1'b0);
    end

    chk("zero done total", zeroSeen, zeroIssued);
    $display("%0d/%0d checks passed", nPass, nChk);
    $finish;
  end

endmodule
